// File: rtl/bus_device_endpoint.sv
// Device-side endpoint for one parallel-bus interface: packs outgoing words into paced push
// pulses, drains received words into a registered valid/ready output, keeps saturating stats.
module bus_device_endpoint #(
  parameter int              BITS  = 65,
  parameter int              ID    = 0,
  parameter int              ID_W  = 8,
  parameter logic [ID_W-1:0] BCST  = {ID_W{1'b1}},
  parameter int              GAP   = 2,
  parameter int              CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_dest,
  input  logic [BITS-ID_W-1:0] in_data,
  output logic                 push,
  output logic [BITS-1:0]      D_push,
  input  logic                 pndng,
  output logic                 pop,
  input  logic [BITS-1:0]      D_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_src_dest,
  output logic [BITS-ID_W-1:0] out_data,
  output logic                 out_bcast,
  output logic                 err_self,
  output logic [CNT_W-1:0]     tx_cnt,
  output logic [CNT_W-1:0]     rx_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int               DW       = BITS - ID_W;
  localparam int               GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [ID_W-1:0]  OWN_ID   = ID_W'(ID);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [GW-1:0]    gap_cnt_reg;
  logic             run_reg;
  logic             tx_fire;
  logic             tx_self;
  logic             tx_push;
  logic [2:0]       cnt_evt;
  logic [CNT_W-1:0] cnt_reg [0:2];

  assign in_ready = !reset && (gap_cnt_reg == '0);
  assign tx_fire  = in_valid && in_ready;
  // A word addressed to ourselves is dropped, unless our id doubles as the broadcast id.
  assign tx_self  = (in_dest == OWN_ID) && (OWN_ID != BCST);
  assign tx_push  = tx_fire && !tx_self;

  // run_reg keeps pop low in the cycle reset is released.
  assign pop = run_reg && !reset && pndng && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_reg <= '0;
      push        <= 1'b0;
      D_push      <= '0;
      err_self    <= 1'b0;
    end else begin
      push     <= tx_push;
      err_self <= tx_fire && tx_self;
      if (tx_push) begin
        D_push      <= {in_dest, in_data};
        gap_cnt_reg <= GAP_LOAD;
      end else if (gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_src_dest <= '0;
      out_data     <= '0;
      out_bcast    <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_src_dest <= D_pop[BITS-1 -: ID_W];
      out_data     <= D_pop[DW-1:0];
      out_bcast    <= (D_pop[BITS-1 -: ID_W] == BCST);
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  assign cnt_evt = {tx_fire && tx_self, pop, tx_push};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_evt[i] && (cnt_reg[i] != CNT_MAX)) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end
      end
    end
  end

  assign tx_cnt   = cnt_reg[0];
  assign rx_cnt   = cnt_reg[1];
  assign drop_cnt = cnt_reg[2];

endmodule

// File: tb/tb_bus_device_endpoint.sv
// Scoreboard bench for bus_device_endpoint: TX words and RX words are queued when driven
// and compared when the endpoint emits push or hands a word to the consumer.
module tb_bus_device_endpoint;

  localparam int BITS  = 65;
  localparam int ID_W  = 8;
  localparam int ID    = 1;
  localparam int GAP   = 3;
  localparam int CNT_W = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   in_dest;
  logic [56:0]       in_data;
  logic              push;
  logic [BITS-1:0]   D_push;
  logic              pndng;
  logic              pop;
  logic [BITS-1:0]   D_pop;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_src_dest;
  logic [56:0]       out_data;
  logic              out_bcast;
  logic              err_self;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  bus_device_endpoint #(
    .BITS(BITS), .ID(ID), .ID_W(ID_W), .BCST(8'hFF), .GAP(GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .push(push), .D_push(D_push),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_src_dest(out_src_dest),
    .out_data(out_data), .out_bcast(out_bcast), .err_self(err_self),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model of the interface receive FIFO feeding pndng/D_pop.
  logic [BITS-1:0] ifm [0:63];
  logic [7:0]      wr = 8'd0;
  logic [7:0]      rd = 8'd0;
  assign pndng = (wr != rd);
  assign D_pop = ifm[rd[5:0]];

  logic [BITS-1:0] tx_q [$];
  logic [BITS-1:0] rx_q [$];
  int exp_tx = 0, exp_rx = 0, exp_drop = 0;
  int cyc = 0, last_push = -1, last_deliv = -1;
  int pop_cnt = 0, err_seen = 0;
  bit gap_chk = 0, rx_consec = 0, pop_pend = 0, hold_v = 0;
  logic [56:0] hold_d;

  always @(negedge clk) begin
    logic [BITS-1:0] w;
    if (!reset) begin
      cyc++;
      check("pop_gate", pop && !pndng, 0);
      if (push) begin
        check("tx_pending", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
          w = tx_q.pop_front();
          check("tx_word", D_push, w);
        end
        if (gap_chk && last_push >= 0) check("tx_gap", cyc - last_push, GAP);
        last_push = cyc;
      end
      if (err_self) err_seen++;
      if (pop) begin
        pop_pend = 1;
        pop_cnt++;
      end
      if (out_valid && out_ready) begin
        check("rx_pending", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          w = rx_q.pop_front();
          check("rx_hdr", out_src_dest, w[64:57]);
          check("rx_data", out_data, w[56:0]);
          check("rx_bcast", out_bcast, w[64:57] == 8'hFF);
        end
        if (rx_consec && last_deliv >= 0) check("rx_consec", cyc - last_deliv, 1);
        last_deliv = cyc;
        hold_v = 0;
      end else if (out_valid) begin
        if (hold_v) check("rx_hold", out_data, hold_d);
        hold_v = 1;
        hold_d = out_data;
      end else begin
        hold_v = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      rd = rd + 8'd1;
      pop_pend = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [BITS-1:0] w);
    ifm[wr[5:0]] = w;
    wr = wr + 8'd1;
    rx_q.push_back(w);
    exp_rx++;
  endtask

  task automatic send(input logic [7:0] d, input logic [56:0] p, output int waited);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = p;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", waited, 0);
    end else if (d != ID) begin
      tx_q.push_back({d, p});
      if (exp_tx != 15) exp_tx++;
    end else begin
      exp_drop++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rx();
    int n = 0;
    while (rx_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("rx_drain", rx_q.size(), 0);
    tick();
  endtask

  initial begin
    int w;
    int pc;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_dest   = 8'h02;
    in_data   = 57'd77;
    out_ready = 1'b1;
    put({8'h05, 57'h1234});
    repeat (3) tick();
    check("rst_push", push, 0);
    check("rst_pop", pop, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_counts", {tx_cnt, rx_cnt, drop_cnt}, 0);

    reset = 1'b0;
    check("release_pop", pop, 0);
    send(8'h02, 57'd77, w);
    check("acc_after_rst", w, 0);
    check("tx_latency", push, 1);

    // Paced transmits: push pulses three cycles apart.
    repeat (4) tick();
    gap_chk = 1;
    last_push = -1;
    for (int i = 1; i <= 3; i++) send(8'h02, 57'(i), w);
    repeat (3) tick();
    gap_chk = 0;
    check("tx_cnt_gap", tx_cnt, exp_tx);

    // Self-addressed word is dropped and does not throttle the next accept.
    send(8'h01, 57'd5, w);
    check("self_err", err_self, 1);
    check("self_nopush", push, 0);
    send(8'h00, 57'd6, w);
    check("self_next_acc", w, 0);
    check("drop_cnt1", drop_cnt, 1);

    put({8'hFF, 57'h1AB});
    put({8'h03, 57'h2CD});
    wait_rx();

    // Backpressure: only the first of three words may be popped while the consumer stalls.
    out_ready = 1'b0;
    pc = pop_cnt;
    put({8'h10, 57'h111});
    put({8'h11, 57'h222});
    put({8'h12, 57'h333});
    repeat (5) tick();
    check("bp_pops", pop_cnt - pc, 1);
    check("bp_valid", out_valid, 1);
    rx_consec = 1;
    last_deliv = -1;
    out_ready = 1'b1;
    wait_rx();
    rx_consec = 0;
    check("bp_final_valid", out_valid, 0);
    check("rx_cnt", rx_cnt, exp_rx);

    for (int i = 0; i < 20; i++) send(8'h04, 57'(100 + i), w);
    repeat (4) tick();
    check("tx_cnt_sat", tx_cnt, exp_tx);
    check("tx_q_left", tx_q.size(), 0);
    check("drop_cnt", drop_cnt, exp_drop);
    check("err_pulses", err_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_device_endpoint.md
Name: bus_device_endpoint

Overview:
Per-device endpoint sitting directly upstream and downstream of one parallel-bus interface instance (prll_bs_ntrfs_riscv plus its FIFOs) in Top_bus. TX side: takes {destination, payload} from a local producer over a valid/ready handshake, packs bus words and drives push/D_push with a programmable minimum inter-push gap. RX side: drains the interface through pndng/pop/D_pop into a registered valid/ready output, splits the header and flags broadcasts. Saturating TX/RX/drop statistics counters.

Parameters:
BITS, 65, bus word width; must match the interface `bits`
ID, 0, own device id; must match the interface `id`
ID_W, 8, destination field width; field is word[BITS-1:BITS-ID_W]
BCST, {ID_W{1'b1}}, broadcast destination value
GAP, 2, minimum clock cycles from one push pulse to the next (>=1)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  producer has a word
in_ready  out  1  endpoint accepts the word this cycle
in_dest  in  ID_W  destination id
in_data  in  BITS-ID_W  payload
push  out  1  to interface push; one-cycle pulse per word
D_push  out  BITS  to interface D_push = {dest, payload}
pndng  in  1  interface has a received word
pop  out  1  to interface pop
D_pop  in  BITS  interface head word; valid while pndng=1
out_valid  out  1  received word held
out_ready  in  1  consumer takes the word
out_src_dest  out  ID_W  header field of the received word
out_data  out  BITS-ID_W  payload of the received word
out_bcast  out  1  header == BCST
err_self  out  1  one-cycle pulse: a word addressed to ID was dropped
tx_cnt, rx_cnt, drop_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (async assert, sync release): push=0, D_push=0, pop=0, out_valid=0, out_src_dest=0, out_data=0, out_bcast=0, err_self=0, all counters=0, gap_cnt=0, in_ready=0 while reset=1.
- TX accept: in_ready = !reset && gap_cnt==0. Transfer happens when in_valid && in_ready.
- On transfer with in_dest != ID: the next cycle shows push=1 and D_push={in_dest,in_data} (latency 1). gap_cnt loads GAP-1 and decrements to 0. With GAP=1, back-to-back pushes are allowed every cycle. D_push holds its last value when push=0. tx_cnt increments.
- On transfer with in_dest == ID (and ID != BCST): no push. The next cycle shows err_self=1. drop_cnt increments. gap_cnt is not loaded.
- in_dest == BCST is a legal transmit.
- RX: pop = pndng && (!out_valid || out_ready), combinational. When pop=1 on a clock edge, the output registers load D_pop. out_valid=1, out_src_dest=D_pop[BITS-1:BITS-ID_W], out_data=the low part, out_bcast=(header==BCST), rx_cnt increments.
- When out_valid && out_ready && !pndng: out_valid clears next cycle. Held data stays stable while out_valid && !out_ready.
- Simultaneous take and refill (out_ready=1, pndng=1): one-cycle throughput, no bubble. pop is never 1 while pndng=0.
- Counters saturate at all-ones and do not wrap.
- If TX and RX events occur in the same cycle, they are independent and both counters update.
- Reset asserted mid-transfer: a pending push is lost and the held RX word is discarded. No pop or push is issued during reset or in the cycle reset releases.

Test Plan:
- Reset: hold reset with in_valid=1 and pndng=1 -> push=0, pop=0, in_ready=0, all counters 0. Release reset -> first push appears 1 cycle after the first accept.
- TX gap: GAP=3, in_valid held high with dest=2, data=1,2,3 -> push pulses at cycles t+1, t+4, t+7. D_push=={8'h02,57'd1}..{8'h02,57'd3}. tx_cnt=3.
- Self-address: ID=1, send dest=1 -> no push, err_self pulse, drop_cnt=1. A following dest=0 word is accepted in the very next cycle.
- RX backpressure: interface holds 3 words, out_ready=0 for 5 cycles -> exactly 1 pop, out_data stable. Then out_ready=1 -> remaining 2 words delivered on consecutive cycles. rx_cnt=3, final out_valid=0.
- Broadcast: D_pop header 8'hFF -> out_bcast=1. Header 8'h03 -> out_bcast=0.
- Saturation: CNT_W=4, 20 transmits -> tx_cnt stays at 4'hF.
